// File: rtl/byte_output_handshake_pkg.sv
// Shared types and constants for the byte output handshake block.
package byte_output_handshake_pkg;

  // Width of one transmitted byte.
  localparam int BYTE_W = 8;

  // Transmit FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/byte_output_handshake_sync.sv
// Single-bit two-flop synchroniser for an asynchronous input.
module byte_output_handshake_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the first flop may go metastable, the second filters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/byte_output_handshake.sv
// Byte transmitter: small FIFO from the core, drained to an asynchronous
// consumer over a 4-phase req/ack handshake.
module byte_output_handshake
  import byte_output_handshake_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              idle,
  output logic              overflow,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_req,
  input  logic              out_ack
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              idle_q, idle_d;
  logic              overflow_q, overflow_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic              out_req_q, out_req_d;
  state_e            state_q, state_d;

  logic ack_s;
  logic push;
  logic pop;

  byte_output_handshake_sync u_ack_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (out_ack),
    .q_o   (ack_s)
  );

  // A write is taken only while not full; a pop in the same cycle does not
  // make room because full is the registered view of the count.
  assign push = wr_en && !full_q;

  // Byte storage; no reset needed, contents are only read behind the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FSM next state, pop decision and handshake outputs.
  always_comb begin
    state_d    = state_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A stale-high ack must clear before a new transfer may start.
        if ((count_q != CNT_ZERO) && !ack_s) begin
          pop        = 1'b1;
          out_data_d = mem_q[rd_ptr_q];
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Data has been stable for a full clock; now raise req.
        out_req_d = 1'b1;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        if (ack_s) begin
          out_req_d = 1'b0;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer/count bookkeeping and registered status flags.
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    full_d     = (count_d == CNT_FULL);
    idle_d     = (count_d == CNT_ZERO) && (state_d == ST_IDLE);
    overflow_d = overflow_q || (wr_en && full_q);
  end

  // State register; reset discards any queued bytes and drops req at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      idle_q     <= 1'b1;
      overflow_q <= 1'b0;
      out_data_q <= '0;
      out_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      idle_q     <= idle_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
      out_req_q  <= out_req_d;
    end
  end

  assign full     = full_q;
  assign idle     = idle_q;
  assign overflow = overflow_q;
  assign out_data = out_data_q;
  assign out_req  = out_req_q;

endmodule

// File: tb/tb_byte_output_handshake.sv
// Directed bench for byte_output_handshake: a cycle table for one byte,
// then hand-written burst, overflow, stale-ack and mid-transfer reset cases.
module tb_byte_output_handshake;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, idle, overflow, out_req, out_ack;
  logic [7:0] out_data;

  int errors = 0;
  int checks = 0;

  // Consumer: either forced directly or an ack that follows req by ack_delay clocks.
  logic        ack_force_en = 1'b1;
  logic        ack_force_val = 1'b0;
  int          ack_delay = 3;
  logic [31:0] hist;
  logic        model_ack;

  assign model_ack = hist[ack_delay-1];
  assign out_ack   = ack_force_en ? ack_force_val : model_ack;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist <= '0;
    else          hist <= {hist[30:0], out_req};
  end

  // Delivery monitor: log the byte at every req rise, watch data stability.
  logic [7:0] delivered[$];
  logic       req_prev = 1'b0;
  logic [7:0] held = 8'h00;
  int         stab_err = 0;
  logic       saw_ff = 1'b0;

  always @(negedge clk) begin
    if (out_req && !req_prev) begin
      delivered.push_back(out_data);
      held <= out_data;
    end
    if (out_req && req_prev && (out_data != held)) stab_err <= stab_err + 1;
    if (out_data == 8'hFF) saw_ff <= 1'b1;
    req_prev <= out_req;
  end

  byte_output_handshake #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .idle     (idle),
    .overflow (overflow),
    .out_data (out_data),
    .out_req  (out_req),
    .out_ack  (out_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       ack;
    logic       exp_req;
    logic [7:0] exp_data;
    logic       exp_full;
    logic       exp_idle;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    wr_en   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    delivered.delete();
  endtask

  task automatic write_burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_deliv(input int n, input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (delivered.size() >= n && idle) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    // Single byte 0x41, ack driven by hand 1 clk after req rises.
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1};

    // Reset state.
    ack_force_en  = 1'b1;
    ack_force_val = 1'b0;
    do_reset();
    chk("rst_req", 32'(out_req), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Cycle table: inputs before an edge, outputs checked 1 time unit after.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_en         = tbl[k].wr;
      wr_data       = tbl[k].d;
      ack_force_val = tbl[k].ack;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_req", k), 32'(out_req), 32'(tbl[k].exp_req));
      chk($sformatf("tbl%0d_data", k), 32'(out_data), 32'(tbl[k].exp_data));
      chk($sformatf("tbl%0d_full", k), 32'(full), 32'(tbl[k].exp_full));
      chk($sformatf("tbl%0d_idle", k), 32'(idle), 32'(tbl[k].exp_idle));
      chk($sformatf("tbl%0d_ovf", k), 32'(overflow), 32'd0);
    end
    chk("single_count", 32'(delivered.size()), 32'd1);
    $display("single byte: %0d delivered, out_data=%02h", delivered.size(), out_data);

    // Burst of five into DEPTH=4 with a slow consumer.
    ack_force_en = 1'b0;
    ack_delay    = 10;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("burst_full", 32'(full), 32'd1);
    wait_deliv(5, 1000, "burst_timeout");
    chk("burst_count", 32'(delivered.size()), 32'd5);
    for (int i = 0; i < 5 && i < delivered.size(); i++) begin
      chk($sformatf("burst_byte%0d", i), 32'(delivered[i]), 32'(8'h10 + 8'(i)));
    end
    chk("burst_ovf", 32'(overflow), 32'd0);
    chk("burst_full_end", 32'(full), 32'd0);
    $display("burst: %0d bytes delivered", delivered.size());

    // Overflow: ack held high so nothing drains, then one write too many.
    ack_force_en  = 1'b1;
    ack_force_val = 1'b0;
    do_reset();
    ack_force_val = 1'b1;
    repeat (3) @(negedge clk);
    write_burst(8'hA0, 4);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_pre", 32'(overflow), 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_req_blocked", 32'(out_req), 32'd0);
    ack_delay    = 3;
    ack_force_en = 1'b0;
    wait_deliv(4, 1000, "ovf_timeout");
    chk("ovf_count", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < 4 && i < delivered.size(); i++) begin
      chk($sformatf("ovf_byte%0d", i), 32'(delivered[i]), 32'(8'hA0 + 8'(i)));
    end
    chk("ovf_after_drain", 32'(overflow), 32'd1);
    chk("ovf_no_ff", 32'(saw_ff), 32'd0);
    $display("overflow: overflow=%0d, %0d bytes delivered", overflow, delivered.size());

    // Stale ack: ack high across reset release, then a write.
    ack_force_en  = 1'b1;
    ack_force_val = 1'b1;
    do_reset();
    chk("stale_ovf_cleared", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stale_hold%0d", i), 32'(out_req), 32'd0);
    end
    chk("stale_data_hold", 32'(out_data), 32'h00);
    ack_force_val = 1'b0;
    @(negedge clk);
    chk("stale_e1_req", 32'(out_req), 32'd0);
    @(negedge clk);
    chk("stale_e2_req", 32'(out_req), 32'd0);
    @(negedge clk);
    chk("stale_e3_req", 32'(out_req), 32'd0);
    chk("stale_e3_data", 32'(out_data), 32'h55);
    @(negedge clk);
    chk("stale_e4_req", 32'(out_req), 32'd1);
    ack_force_en = 1'b0;
    wait_deliv(1, 200, "stale_timeout");
    chk("stale_byte", 32'(delivered.size() > 0 ? delivered[0] : 8'h00), 32'h55);
    $display("stale ack: delivered %0d byte(s)", delivered.size());

    // Reset while in REQ with two bytes still queued.
    ack_force_en = 1'b0;
    ack_delay    = 20;
    do_reset();
    write_burst(8'hB0, 3);
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (out_req) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("mid_req_seen", 32'(got), 32'd1);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_req_async", 32'(out_req), 32'd0);
    chk("mid_data_async", 32'(out_data), 32'h00);
    chk("mid_idle_async", 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_idle_after", 32'(idle), 32'd1);
    repeat (40) @(negedge clk);
    chk("mid_count", 32'(delivered.size()), 32'd1);
    chk("mid_byte", 32'(delivered.size() > 0 ? delivered[0] : 8'h00), 32'hB0);
    chk("mid_req_end", 32'(out_req), 32'd0);
    chk("mid_idle_end", 32'(idle), 32'd1);
    $display("mid reset: %0d byte(s) presented", delivered.size());

    chk("data_stable", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
